// File: rtl/sort_seq_ctrl.sv
// Area-optimised four-element unsigned sorter: a controller FSM time-shares a
// single min/max compare-exchange unit over a 6-step bubble schedule.

module sort_seq_minmax #(
  parameter int unsigned p_nbits = 8
) (
  input  logic [p_nbits-1:0] a,
  input  logic [p_nbits-1:0] b,
  output logic [p_nbits-1:0] lo_c,
  output logic [p_nbits-1:0] hi_c
);

  // Swap only when strictly out of order so equal operands pass straight through.
  always_comb begin
    lo_c = a;
    hi_c = b;
    if (b < a) begin
      lo_c = b;
      hi_c = a;
    end
  end

endmodule

module sort_seq_ctrl #(
  parameter int unsigned p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3
);

  localparam int unsigned STEP_W   = 3;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned N_ELEM   = 4;
  localparam int unsigned LAST_STEP = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [p_nbits-1:0]  e_q [N_ELEM];
  logic [p_nbits-1:0]  e_d [N_ELEM];
  logic                in_rdy_q, in_rdy_d;
  logic                out_val_q, out_val_d;

  logic [IDX_W-1:0]    lo_idx_c;
  logic [IDX_W-1:0]    hi_idx_c;
  logic [p_nbits-1:0]  cx_a_c, cx_b_c;
  logic [p_nbits-1:0]  cx_lo_c, cx_hi_c;

  // Bubble schedule: lower index of the adjacent pair visited at each step.
  always_comb begin
    lo_idx_c = IDX_W'(0);
    case (step_q)
      3'd0: lo_idx_c = IDX_W'(0);
      3'd1: lo_idx_c = IDX_W'(1);
      3'd2: lo_idx_c = IDX_W'(2);
      3'd3: lo_idx_c = IDX_W'(0);
      3'd4: lo_idx_c = IDX_W'(1);
      3'd5: lo_idx_c = IDX_W'(0);
      default: lo_idx_c = IDX_W'(0);
    endcase
  end

  assign hi_idx_c = IDX_W'(lo_idx_c + IDX_W'(1));
  assign cx_a_c   = e_q[lo_idx_c];
  assign cx_b_c   = e_q[hi_idx_c];

  sort_seq_minmax #(
    .p_nbits (p_nbits)
  ) u_minmax (
    .a    (cx_a_c),
    .b    (cx_b_c),
    .lo_c (cx_lo_c),
    .hi_c (cx_hi_c)
  );

  // Next-state, element write-back and handshake flags.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    for (int i = 0; i < N_ELEM; i++) e_d[i] = e_q[i];

    case (state_q)
      IDLE: begin
        if (in_val && in_rdy_q) begin
          e_d[0]  = in0;
          e_d[1]  = in1;
          e_d[2]  = in2;
          e_d[3]  = in3;
          step_d  = STEP_W'(0);
          state_d = SORT;
        end
      end
      SORT: begin
        e_d[lo_idx_c] = cx_lo_c;
        e_d[hi_idx_c] = cx_hi_c;
        if (step_q == STEP_W'(LAST_STEP)) begin
          step_d  = STEP_W'(0);
          state_d = DONE;
        end else begin
          step_d = STEP_W'(step_q + STEP_W'(1));
        end
      end
      DONE: begin
        if (out_val_q && out_rdy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = STEP_W'(0);
      end
    endcase

    in_rdy_d  = (state_d == IDLE);
    out_val_d = (state_d == DONE);
  end

  // in_rdy resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= STEP_W'(0);
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) e_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
      for (int i = 0; i < N_ELEM; i++) e_q[i] <= e_d[i];
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_val = out_val_q;
  assign out0    = e_q[0];
  assign out1    = e_q[1];
  assign out2    = e_q[2];
  assign out3    = e_q[3];

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl: latency, ordering, backpressure,
// back-to-back initiation and asynchronous reset mid-sort.

module tb_sort_seq_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_val;
  logic         in_rdy;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_val;
  logic         out_rdy;
  logic [W-1:0] out0, out1, out2, out3;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sort_seq_ctrl #(.p_nbits(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out0    (out0),
    .out1    (out1),
    .out2    (out2),
    .out3    (out3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, ".out0"}, 32'(out0), 32'(a));
    chk({tag, ".out1"}, 32'(out1), 32'(b));
    chk({tag, ".out2"}, 32'(out2), 32'(c));
    chk({tag, ".out3"}, 32'(out3), 32'(d));
  endtask

  // Fire one input set in the current cycle; returns in cycle T+1 with in_val low.
  task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, ".in_rdy_accept"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in0 = a; in1 = b; in2 = c; in3 = d;
    step();
    in_val = 1'b0;
  endtask

  // Walks cycles T+1..T+6 expecting busy, leaves the bench in cycle T+7.
  task automatic wait_busy(input string tag);
    for (int k = 1; k <= 6; k++) begin
      chk({tag, ".busy_in_rdy"}, 32'(in_rdy), 32'd0);
      chk({tag, ".busy_out_val"}, 32'(out_val), 32'd0);
      step();
    end
  endtask

  task automatic run_set(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [W-1:0] x0, input logic [W-1:0] x1,
                         input logic [W-1:0] x2, input logic [W-1:0] x3);
    out_rdy = 1'b1;
    send(tag, a, b, c, d);
    wait_busy(tag);
    chk({tag, ".out_val_t7"}, 32'(out_val), 32'd1);
    chk_out(tag, x0, x1, x2, x3);
    step();
    chk({tag, ".in_rdy_t8"}, 32'(in_rdy), 32'd1);
    chk({tag, ".out_val_t8"}, 32'(out_val), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;

    // Reset state
    #3;
    chk("rst.in_rdy", 32'(in_rdy), 32'd0);
    chk("rst.out_val", 32'(out_val), 32'd0);
    chk_out("rst", 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    step();
    reset_n = 1'b1;
    chk("rst_rel.in_rdy_same_cycle", 32'(in_rdy), 32'd0);
    step();
    chk("rst_rel.in_rdy_next", 32'(in_rdy), 32'd1);

    // Reverse order straight after reset
    run_set("rev", 8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4);

    // Duplicates and extremes
    run_set("dup", 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255);

    // Already sorted
    run_set("sorted", 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4);

    // Backpressure with ignored in_val pulses
    out_rdy = 1'b0;
    send("bp", 8'd9, 8'd7, 8'd8, 8'd6);
    wait_busy("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp.out_val_hold", 32'(out_val), 32'd1);
      chk("bp.in_rdy_hold", 32'(in_rdy), 32'd0);
      chk_out("bp.hold", 8'd6, 8'd7, 8'd8, 8'd9);
      in_val = (k % 2 == 0);
      in0 = 8'd1; in1 = 8'd1; in2 = 8'd1; in3 = 8'd1;
      step();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    chk("bp.out_val_release", 32'(out_val), 32'd1);
    chk_out("bp.release", 8'd6, 8'd7, 8'd8, 8'd9);
    step();
    chk("bp.in_rdy_after", 32'(in_rdy), 32'd1);
    chk("bp.out_val_after", 32'(out_val), 32'd0);

    // Back-to-back sets with in_val held high
    out_rdy = 1'b1;
    chk("b2b.in_rdy_first", 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in0 = 8'd2; in1 = 8'd1; in2 = 8'd4; in3 = 8'd3;
    step();
    in0 = 8'd8; in1 = 8'd5; in2 = 8'd7; in3 = 8'd6;
    wait_busy("b2b.a");
    chk("b2b.a.out_val", 32'(out_val), 32'd1);
    chk("b2b.a.in_rdy_t7", 32'(in_rdy), 32'd0);
    chk_out("b2b.a", 8'd1, 8'd2, 8'd3, 8'd4);
    step();
    chk("b2b.in_rdy_t8", 32'(in_rdy), 32'd1);
    step();
    in_val = 1'b0;
    wait_busy("b2b.b");
    chk("b2b.b.out_val", 32'(out_val), 32'd1);
    chk_out("b2b.b", 8'd5, 8'd6, 8'd7, 8'd8);
    step();
    chk("b2b.b.in_rdy_after", 32'(in_rdy), 32'd1);

    // Asynchronous reset at step 3 of a sort
    send("mid", 8'd4, 8'd3, 8'd2, 8'd1);
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.rst.out_val", 32'(out_val), 32'd0);
    chk("mid.rst.in_rdy", 32'(in_rdy), 32'd0);
    chk_out("mid.rst", 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    chk("mid.rst_edge.in_rdy", 32'(in_rdy), 32'd0);
    chk("mid.rst_edge.out_val", 32'(out_val), 32'd0);
    #2;
    reset_n = 1'b1;
    chk("mid.rel.in_rdy_same", 32'(in_rdy), 32'd0);
    step();
    chk("mid.rel.in_rdy_next", 32'(in_rdy), 32'd1);
    run_set("after_rst", 8'd3, 8'd1, 8'd2, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
